// File: rtl/flag_basis_ctrl.sv
// flag_basis_ctrl: sequences one flag-basis extraction.
//   IDLE -> LOAD -> UPDATE (num_qubit XOR-updates, one per row_valid)
//        -> [SCAN: num_qubit rotate-lefts, one per scan_ack] -> DONE -> IDLE
// Optional feature macro: FLAG_CTRL_SCAN_EN adds the SCAN state and its
// counter. Without it UPDATE goes straight to DONE and rotate is never issued.
// Flag op codes on load_update_flag: 0 load, 1 XOR-update, 2 rotate-left, 3 no-op.
module flag_basis_ctrl #(
  parameter int num_qubit = 4
) (
  input  logic                           clk,
  input  logic                           rst_new,
  input  logic                           start,
  input  logic                           en_q1,
  input  logic                           en_q2,
  input  logic                           row_valid,
  input  logic                           scan_ack,
  input  logic                           abort,
  output logic                           ld_flag_pos,
  output logic                           ld_flag_pos2,
  output logic [1:0]                     load_update_flag,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(num_qubit+1)-1:0] row_cnt
);

  localparam int CW = $clog2(num_qubit+1);
  localparam logic [CW-1:0] LAST = CW'(num_qubit - 1);

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_XOR  = 2'd1;
  localparam logic [1:0] OP_ROT  = 2'd2;
  localparam logic [1:0] OP_NOP  = 2'd3;

`ifdef FLAG_CTRL_SCAN_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_UPDATE, S_SCAN, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_UPDATE, S_DONE} state_t;
`endif

  state_t        state_q;
  logic          act1_q, act2_q;
  logic [CW-1:0] row_cnt_q;
`ifdef FLAG_CTRL_SCAN_EN
  logic [CW-1:0] scan_cnt_q;
`else
  // scan_ack has no consumer when the scan phase is compiled out
  logic          unused_scan_ack;
  assign unused_scan_ack = scan_ack;
`endif

  // Sequencer: abort wins over everything (including a same-cycle start in IDLE)
  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      state_q    <= S_IDLE;
      act1_q     <= 1'b0;
      act2_q     <= 1'b0;
      row_cnt_q  <= '0;
`ifdef FLAG_CTRL_SCAN_EN
      scan_cnt_q <= '0;
`endif
    end else if (abort) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          act1_q    <= en_q1;
          act2_q    <= en_q2;
          row_cnt_q <= '0;
          // nothing to extract when both channels are off: report completion directly
          state_q   <= (en_q1 | en_q2) ? S_LOAD : S_DONE;
        end
        S_LOAD: begin
          row_cnt_q <= '0;
          state_q   <= S_UPDATE;
        end
        S_UPDATE: if (row_valid) begin
          row_cnt_q <= row_cnt_q + CW'(1);
          if (row_cnt_q == LAST) begin
`ifdef FLAG_CTRL_SCAN_EN
            scan_cnt_q <= '0;
            state_q    <= S_SCAN;
`else
            state_q    <= S_DONE;
`endif
          end
        end
`ifdef FLAG_CTRL_SCAN_EN
        // a full rotation of num_qubit steps restores the original flag order
        S_SCAN: if (scan_ack) begin
          scan_cnt_q <= scan_cnt_q + CW'(1);
          if (scan_cnt_q == LAST) state_q <= S_DONE;
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Flag-channel controls: decoded from state and same-cycle strobes
  always_comb begin
    load_update_flag = OP_NOP;
    ld_flag_pos      = 1'b0;
    ld_flag_pos2     = 1'b0;
    case (state_q)
      S_LOAD: begin
        load_update_flag = OP_LOAD;
        ld_flag_pos      = act1_q;
        ld_flag_pos2     = act2_q;
      end
      S_UPDATE: if (row_valid) begin
        load_update_flag = OP_XOR;
        ld_flag_pos      = act1_q;
        ld_flag_pos2     = act2_q;
      end
`ifdef FLAG_CTRL_SCAN_EN
      S_SCAN: if (scan_ack) begin
        load_update_flag = OP_ROT;
        ld_flag_pos      = act1_q;
        ld_flag_pos2     = act2_q;
      end
`endif
      default: ;
    endcase
    // an aborting cycle must not disturb the flag registers
    if (abort) begin
      ld_flag_pos  = 1'b0;
      ld_flag_pos2 = 1'b0;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE) & ~abort;
  assign row_cnt = row_cnt_q;

endmodule

// File: tb/tb_flag_basis_ctrl.sv
// Bench for flag_basis_ctrl. Each sequence draws random row_valid/scan_ack
// traces, predicts the per-cycle outputs from the sequencing rules (which
// cycles carry updates/rotates, where done lands, abort cut-off), then drives
// the trace and checks every cycle.
module tb_flag_basis_ctrl;
  localparam int N  = 4;
  localparam int L  = 56;
  localparam int CW = $clog2(N+1);

  logic clk = 1'b0;
  logic rst_new, start, en_q1, en_q2, row_valid, scan_ack, abort;
  logic ld_flag_pos, ld_flag_pos2, busy, done;
  logic [1:0]    load_update_flag;
  logic [CW-1:0] row_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  flag_basis_ctrl #(.num_qubit(N)) dut (
    .clk(clk), .rst_new(rst_new), .start(start), .en_q1(en_q1), .en_q2(en_q2),
    .row_valid(row_valid), .scan_ack(scan_ack), .abort(abort),
    .ld_flag_pos(ld_flag_pos), .ld_flag_pos2(ld_flag_pos2),
    .load_update_flag(load_update_flag), .busy(busy), .done(done), .row_cnt(row_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int cnt_before(input int q[$], input int v);
    int n = 0;
    foreach (q[i]) if (q[i] < v) n++;
    return n;
  endfunction

  // ab_at: -1 none, -2 cycle after the 2nd update, else absolute cycle (0 = with start)
  task automatic run_seq(input bit e1, input bit e2, input int dens, input int ab_in);
    bit rv[L];
    bit ak[L];
    int upd[$];
    int acks[$];
    int done_c, ab_at, last_busy;
    bit act, inseq, ab_now;
    logic [1:0] e_code;
    logic e_ld1, e_ld2;
    for (int c = 0; c < L; c++) begin
      rv[c] = ($urandom_range(99) < dens);
      ak[c] = ($urandom_range(99) < dens);
      if (c >= 24 && c <= 31) rv[c] = 1'b1;
      if (c >= 40 && c <= 47) ak[c] = 1'b1;
    end
    act = e1 | e2;
    if (!act) done_c = 1;
    else begin
      for (int c = 2; c < L && upd.size() < N; c++) if (rv[c]) upd.push_back(c);
      done_c = upd[N-1] + 1;
`ifdef FLAG_CTRL_SCAN_EN
      for (int c = done_c; c < L && acks.size() < N; c++) if (ak[c]) acks.push_back(c);
      done_c = acks[N-1] + 1;
`endif
    end
    ab_at = (ab_in == -2) ? (act ? upd[1] + 1 : 1) : ab_in;
    if (ab_at == 0) last_busy = -1;
    else if (ab_at > 0 && ab_at <= done_c) last_busy = ab_at;
    else last_busy = done_c;

    for (int c = 0; c < L; c++) begin
      @(posedge clk);
      #1;
      inseq     = (c >= 1 && c <= last_busy);
      start     = (c == 0) ? 1'b1 : (inseq ? 1'($urandom_range(1)) : 1'b0);
      en_q1     = (c == 0) ? e1 : 1'($urandom_range(1));
      en_q2     = (c == 0) ? e2 : 1'($urandom_range(1));
      row_valid = rv[c];
      scan_ack  = ak[c];
      abort     = (c == ab_at);
      ab_now    = (c == ab_at);
      e_code = 2'd3; e_ld1 = 1'b0; e_ld2 = 1'b0;
      if (inseq && act) begin
        if (c == 1)              begin e_code = 2'd0; e_ld1 = e1; e_ld2 = e2; end
        else if (in_q(upd, c))   begin e_code = 2'd1; e_ld1 = e1; e_ld2 = e2; end
        else if (in_q(acks, c))  begin e_code = 2'd2; e_ld1 = e1; e_ld2 = e2; end
      end
      if (ab_now) begin e_ld1 = 1'b0; e_ld2 = 1'b0; end
      #3;
      chk("busy", busy, inseq);
      chk("done", done, inseq && c == done_c && !ab_now);
      chk("ld_flag_pos", ld_flag_pos, e_ld1);
      chk("ld_flag_pos2", ld_flag_pos2, e_ld2);
      if (!ab_now) chk("load_update_flag", load_update_flag, e_code);
      if (act && c >= 2 && c <= last_busy) chk("row_cnt", row_cnt, cnt_before(upd, c));
    end
    start = 1'b0; abort = 1'b0; row_valid = 1'b0; scan_ack = 1'b0;
  endtask

  initial begin
    int rst_cyc;
    rst_new = 1'b1; start = 1'b0; en_q1 = 1'b0; en_q2 = 1'b0;
    row_valid = 1'b0; scan_ack = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ld", {ld_flag_pos, ld_flag_pos2}, 2'b00);
    chk("rst_code", load_update_flag, 2'd3);
    chk("rst_row_cnt", row_cnt, 0);
    @(posedge clk); #1 rst_new = 1'b0;

    run_seq(1'b1, 1'b0, 50, -1);   // single channel, gapped rows
    run_seq(1'b1, 1'b1, 50, -1);   // both channels
    run_seq(1'b0, 1'b0, 50, -1);   // empty selection
    run_seq(1'b1, 1'b1, 50, -2);   // abort after two updates
    run_seq(1'b0, 1'b1, 40, -1);   // restart after abort
    run_seq(1'b1, 1'b0, 50, 0);    // abort with start in IDLE
    run_seq(1'b0, 1'b1, 100, -1);  // row_valid / scan_ack held high
    for (int k = 0; k < 8; k++)
      run_seq(1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(20, 100)),
              ($urandom_range(3) == 0) ? int'($urandom_range(1, 30)) : -1);

    // Reset mid-sequence (SCAN when built in, UPDATE otherwise), start held high
`ifdef FLAG_CTRL_SCAN_EN
    rst_cyc = 7;
`else
    rst_cyc = 4;
`endif
    for (int c = 0; c < rst_cyc; c++) begin
      @(posedge clk); #1;
      start = 1'b1; en_q1 = 1'b1; en_q2 = 1'b1;
      row_valid = (c >= 2 && c <= 5);
    end
    @(posedge clk); #1;
    row_valid = 1'b0;
    #1 rst_new = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_ld", {ld_flag_pos, ld_flag_pos2}, 2'b00);
    chk("midrst_code", load_update_flag, 2'd3);
    chk("midrst_row_cnt", row_cnt, 0);
    @(posedge clk); #1;
    rst_new = 1'b0; start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #4;
      chk("postrst_busy", busy, 1'b0);
      chk("postrst_done", done, 1'b0);
    end
    run_seq(1'b1, 1'b1, 60, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/flag_basis_ctrl.md
FLAG_BASIS_CTRL -- requirements
Module: flag_basis_ctrl

Interface
REQ-001 The block SHALL have parameter num_qubit, default 4, giving the qubit count and the length of the UPDATE and SCAN phases.
REQ-002 The block SHALL have port clk, input, 1, the system clock.
REQ-003 The block SHALL have port rst_new, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin one extraction sequence.
REQ-005 The block SHALL have ports en_q1 and en_q2, inputs, 1 each, selecting the channels (pos, pos2) that take part; both are sampled when start is accepted.
REQ-006 The block SHALL have port row_valid, input, 1, a strobe marking that one Q x ROW multiply result is valid this cycle.
REQ-007 The block SHALL have port scan_ack, input, 1, a strobe from the consumer that flag[0] has been read.
REQ-008 The block SHALL have port abort, input, 1, a synchronous request to cancel the sequence.
REQ-009 The block SHALL have ports ld_flag_pos and ld_flag_pos2, outputs, 1 each, the load enables for the two flag channels.
REQ-010 The block SHALL have port load_update_flag, output, 2, the flag operation: 0 load, 1 XOR-update, 2 rotate-left, 3 no-op.
REQ-011 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-013 The block SHALL have port row_cnt, output, $clog2(num_qubit+1), the count of updates issued.

Function
REQ-014 The state machine SHALL have the states IDLE, LOAD, UPDATE, SCAN and DONE.
REQ-015 In IDLE, start SHALL be accepted and SHALL latch en_q1 and en_q2 into act1 and act2; the next state is LOAD, or DONE if both enables are low.
REQ-016 LOAD SHALL last one cycle with load_update_flag=0, ld_flag_pos=act1 and ld_flag_pos2=act2, then go to UPDATE with row_cnt cleared.
REQ-017 In UPDATE, each cycle with row_valid high SHALL, in the same cycle and combinationally, drive load_update_flag=1, ld_flag_pos=act1 and ld_flag_pos2=act2, and increment row_cnt at the edge.
REQ-018 Cycles in UPDATE with row_valid low SHALL drive load_update_flag=3 with both load enables low.
REQ-019 When row_cnt reaches num_qubit, the block SHALL leave UPDATE: to SCAN if FLAG_CTRL_SCAN_EN is defined, otherwise to DONE.
REQ-020 On entry to SCAN, the block SHALL clear the scan counter.
REQ-021 In SCAN, each scan_ack SHALL combinationally drive load_update_flag=2 and the active load enables, and SHALL increment the scan counter.
REQ-022 After num_qubit acks in SCAN, the block SHALL go to DONE; this is a full rotation, so the flag order is restored.
REQ-023 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-024 Outside IDLE, start SHALL be ignored.
REQ-025 row_valid outside UPDATE and scan_ack outside SCAN SHALL be ignored.
REQ-026 abort in any non-IDLE state SHALL return the block to IDLE at the next edge without a done pulse; abort SHALL gate the load enables low in its own cycle.
REQ-027 If abort and start are high together in IDLE, abort SHALL win and start SHALL be dropped.
REQ-028 In IDLE and DONE, both load enables SHALL be 0 and load_update_flag SHALL be 3.

Reset
REQ-029 On rst_new, the block SHALL go to IDLE with act1, act2, row_cnt and the scan counter at 0.
REQ-030 During rst_new, done, busy, ld_flag_pos and ld_flag_pos2 SHALL be 0 and load_update_flag SHALL be 3.
REQ-031 rst_new asserted mid-sequence SHALL discard the sequence with no done pulse.

Configuration
REQ-032 The macro FLAG_CTRL_SCAN_EN SHALL include the SCAN state and the scan counter when defined.
REQ-033 Without FLAG_CTRL_SCAN_EN, UPDATE SHALL go straight to DONE, scan_ack SHALL be unused and rotate (code 2) SHALL never be issued.

Verification
REQ-034 Scenario: num_qubit=4, start with en_q1=1, en_q2=0, then 4 row_valid pulses with gaps -> one LOAD cycle with ld_flag_pos=1 and code 0; 4 code-1 cycles aligned to row_valid; ld_flag_pos2 never high; done 1 cycle after the 4th update (scan disabled).
REQ-035 Scenario: FLAG_CTRL_SCAN_EN defined, both enables high, 4 rows then 4 scan_acks -> both load enables high on each code-2 cycle; done one cycle after the 4th ack; row_cnt=4.
REQ-036 Scenario: start with en_q1=en_q2=0 -> no load enable ever high; busy high for 1 cycle; done pulse.
REQ-037 Scenario: abort after 2 row_valid pulses -> IDLE next cycle; no done; a new start is accepted afterwards with row_cnt reset.
REQ-038 Scenario: rst_new pulsed during SCAN, with start held high in UPDATE -> outputs at reset values; a second start while busy causes no restart.
REQ-039 Scenario: row_valid held high continuously -> exactly 4 updates, and the 5th cycle issues no code 1.
